// File: rtl/uart_tx_buffered.sv
// ============================================================================
// uart_tx_buffered
// ----------------------------------------------------------------------------
// Buffered 8N1 UART transmitter. Bytes written over a valid/ready port are
// queued in a circular FIFO and serialized LSB-first onto o_Tx_Serial at
// CLKS_PER_BIT clocks per bit. The core can burst several bytes without
// waiting for each frame to finish.
//
// Optional feature macro: UART_TX_PARITY_EN
//   Defined   : an even-parity bit follows the data bits (11-bit frame).
//   Undefined : plain 8N1 (10-bit frame), and no parity logic is built.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (must be >= 2)
//   FIFO_AW       FIFO address width; depth = 2**FIFO_AW bytes
//
// Ports:
//   i_Clock       system clock
//   i_Rst_n       asynchronous active-low reset
//   i_Wr_DV       write strobe; byte accepted when i_Wr_DV && o_Wr_Ready
//   i_Wr_Byte     byte to queue
//   o_Wr_Ready    FIFO not full
//   i_Clr_Ovf     clears o_Overflow (a simultaneous overflow wins)
//   o_Overflow    sticky: a write was attempted while the FIFO was full
//   o_Fifo_Level  bytes queued, excluding the byte currently being sent
//   o_Tx_Serial   serial line, idle high, registered
//   o_Tx_Active   high from the first start-bit cycle to the last stop-bit cycle
//   o_Tx_Done     one-cycle pulse on the last cycle of each stop bit
//
// Timing summary: a write accepted at edge N into an empty FIFO is popped by
// the FSM at edge N+1 and the start bit appears on the line after edge N+2.
// All line-side outputs are registered from the state held during the
// previous cycle, so they trail the FSM state by exactly one clock.
// ============================================================================
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 100,
   parameter int FIFO_AW      = 4
) (
   input  logic               i_Clock,
   input  logic               i_Rst_n,
   input  logic               i_Wr_DV,
   input  logic [7:0]         i_Wr_Byte,
   output logic               o_Wr_Ready,
   input  logic               i_Clr_Ovf,
   output logic               o_Overflow,
   output logic [FIFO_AW:0]   o_Fifo_Level,
   output logic               o_Tx_Serial,
   output logic               o_Tx_Active,
   output logic               o_Tx_Done
);

   // ------------------------------------------------------------------------
   // Local constants
   // ------------------------------------------------------------------------
   localparam int                 DEPTH     = 1 << FIFO_AW;
   localparam int                 TW        = $clog2(CLKS_PER_BIT);
   localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
   localparam logic [TW-1:0]      TMR_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]      TMR_ONE   = TW'(1);

   // ------------------------------------------------------------------------
   // FSM state encoding; the PARITY state only exists when the feature is on
   // ------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } state_t;
`endif

   // ------------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------------
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic               overflow;

   // ------------------------------------------------------------------------
   // Transmitter state
   // ------------------------------------------------------------------------
   state_t             state;
   logic [TW-1:0]      timer;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift;
   logic               tx_serial;
   logic               tx_active;
   logic               tx_done;
`ifdef UART_TX_PARITY_EN
   logic               parity_bit;
`endif

   logic               push;
   logic               pop;
   logic               timer_last;
   logic [7:0]         head;

   // Ready is decoded from the registered occupancy, never from this cycle's
   // pop, so a full FIFO refuses a write even if the FSM pops in the same
   // cycle; ready comes back the cycle after that pop.
   assign o_Wr_Ready   = (count != LVL_FULL);
   assign push         = i_Wr_DV && o_Wr_Ready;
   assign pop          = (state == ST_IDLE) && (count != '0);
   assign head         = mem[rd_ptr];
   assign timer_last   = (timer == TMR_LAST);

   assign o_Overflow   = overflow;
   assign o_Fifo_Level = count;
   assign o_Tx_Serial  = tx_serial;
   assign o_Tx_Active  = tx_active;
   assign o_Tx_Done    = tx_done;

   // ------------------------------------------------------------------------
   // FIFO data array
   // ------------------------------------------------------------------------
   // NOTE: the storage array has no reset; the pointers and occupancy count
   // define which entries are valid, so stale contents are never observed.
   always_ff @(posedge i_Clock) begin
      if (push) begin
         mem[wr_ptr] <= i_Wr_Byte;
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers, occupancy and sticky overflow
   // ------------------------------------------------------------------------
   // NOTE: every register updates with non-blocking assignments so all state
   // in the block samples the same pre-edge values, independent of order.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end

         // Push and pop together leave the occupancy unchanged.
         unique case ({push, pop})
            2'b10:   count <= count + LVL_ONE;
            2'b01:   count <= count - LVL_ONE;
            default: count <= count;
         endcase

         // A write while full sets the flag and beats a same-cycle clear.
         if (i_Wr_DV && !o_Wr_Ready) begin
            overflow <= 1'b1;
         end else if (i_Clr_Ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Transmit FSM with registered line outputs
   //
   // Each branch sets the line value for the state it is currently in; the
   // value lands on o_Tx_Serial after the edge, which is why the start bit
   // shows up one clock after IDLE pops the byte. The bit timer is reloaded
   // to zero on every state change.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state      <= ST_IDLE;
         timer      <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         tx_serial  <= 1'b1;
         tx_active  <= 1'b0;
         tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               tx_serial <= 1'b1;
               tx_active <= 1'b0;
               if (pop) begin
                  shift      <= head;
                  bit_cnt    <= '0;
                  timer      <= '0;
`ifdef UART_TX_PARITY_EN
                  // Even parity: the parity bit makes the count of ones even.
                  parity_bit <= ^head;
`endif
                  state      <= ST_START;
               end
            end

            ST_START: begin
               tx_serial <= 1'b0;
               tx_active <= 1'b1;
               if (timer_last) begin
                  timer <= '0;
                  state <= ST_DATA;
               end else begin
                  timer <= timer + TMR_ONE;
               end
            end

            ST_DATA: begin
               tx_serial <= shift[0];
               tx_active <= 1'b1;
               if (timer_last) begin
                  timer   <= '0;
                  shift   <= shift >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end
               end else begin
                  timer <= timer + TMR_ONE;
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               tx_serial <= parity_bit;
               tx_active <= 1'b1;
               if (timer_last) begin
                  timer <= '0;
                  state <= ST_STOP;
               end else begin
                  timer <= timer + TMR_ONE;
               end
            end
`endif

            ST_STOP: begin
               tx_serial <= 1'b1;
               tx_active <= 1'b1;
               if (timer_last) begin
                  // Lands on the final stop-bit cycle of the line.
                  tx_done <= 1'b1;
                  timer   <= '0;
                  state   <= ST_IDLE;
               end else begin
                  timer <= timer + TMR_ONE;
               end
            end

            default: begin
               tx_serial <= 1'b1;
               tx_active <= 1'b0;
               timer     <= '0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// tb_uart_tx_buffered
// ----------------------------------------------------------------------------
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4 and FIFO_AW=2
// (depth 4). Inputs are driven and outputs sampled 1 time unit after the
// rising edge. Covers reset idle, a single frame, a three-byte burst, FIFO
// fill/overflow, reset mid-frame and, with UART_TX_PARITY_EN, parity frames.
// ============================================================================
module tb_uart_tx_buffered;

   localparam int CPB     = 4;
   localparam int AW      = 2;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS   = 11;
`else
   localparam int NBITS   = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic          clk;
   logic          rst_n;
   logic          wr_dv;
   logic [7:0]    wr_byte;
   logic          wr_ready;
   logic          clr_ovf;
   logic          overflow;
   logic [AW:0]   fifo_level;
   logic          tx_serial;
   logic          tx_active;
   logic          tx_done;

   int checks   = 0;
   int failures = 0;

   uart_tx_buffered #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (AW)
   ) dut (
      .i_Clock      (clk),
      .i_Rst_n      (rst_n),
      .i_Wr_DV      (wr_dv),
      .i_Wr_Byte    (wr_byte),
      .o_Wr_Ready   (wr_ready),
      .i_Clr_Ovf    (clr_ovf),
      .o_Overflow   (overflow),
      .o_Fifo_Level (fifo_level),
      .o_Tx_Serial  (tx_serial),
      .o_Tx_Active  (tx_active),
      .o_Tx_Done    (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_dv   = 1'b1;
      wr_byte = b;
      tick();
      wr_dv   = 1'b0;
   endtask

   // Expected line level for frame bit idx: start, data LSB first,
   // optional even parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Called while sampling frame cycle 1; returns while sampling the last
   // frame cycle. Checks line, active and done on every cycle.
   task automatic check_frame(input string tag, input logic [7:0] d);
      for (int j = 0; j < FRAME_CYC; j++) begin
         if (j != 0) tick();
         check({tag, "_serial"}, 32'(tx_serial), 32'(frame_bit(d, j / CPB)));
         check({tag, "_active"}, 32'(tx_active), 32'd1);
         check({tag, "_done"},   32'(tx_done),   32'(j == FRAME_CYC - 1));
      end
   endtask

   initial begin
      int  low_cnt;
      int  done_cnt;
      logic seen;

      rst_n   = 1'b0;
      wr_dv   = 1'b0;
      wr_byte = 8'h00;
      clr_ovf = 1'b0;

      // ---------------- reset idle ----------------
      repeat (2) tick();
      check("rst_serial",   32'(tx_serial),  32'd1);
      check("rst_ready",    32'(wr_ready),   32'd1);
      check("rst_level",    32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow),   32'd0);
      check("rst_active",   32'(tx_active),  32'd0);
      check("rst_done",     32'(tx_done),    32'd0);
      rst_n = 1'b1;
      low_cnt = 0;
      repeat (10) begin
         tick();
         if (tx_serial !== 1'b1 || tx_active !== 1'b0) low_cnt++;
      end
      check("idle_after_reset", 32'(low_cnt), 32'd0);

      // ---------------- single byte 0xA5 ----------------
      write_byte(8'hA5);                       // edge N
      check("single_level_n",   32'(fifo_level), 32'd1);
      tick();                                  // edge N+1: popped
      check("single_level_n1",  32'(fifo_level), 32'd0);
      check("single_serial_n1", 32'(tx_serial),  32'd1);
      check("single_active_n1", 32'(tx_active),  32'd0);
      tick();                                  // edge N+2: start bit
      check_frame("a5", 8'hA5);
      tick();
      check("single_end_serial", 32'(tx_serial), 32'd1);
      check("single_end_active", 32'(tx_active), 32'd0);
      check("single_end_done",   32'(tx_done),   32'd0);
      repeat (3) tick();

      // ---------------- burst 0x00, 0xFF, 0x55 ----------------
      wr_dv = 1'b1;
      wr_byte = 8'h00; tick();                 // edge N
      wr_byte = 8'hFF; tick();                 // edge N+1: push + pop
      wr_byte = 8'h55; tick();                 // edge N+2: push, frame starts
      wr_dv = 1'b0;
      check("burst_level_after_3rd", 32'(fifo_level), 32'd2);
      check_frame("b00", 8'h00);
      tick();
      check("burst_gap1_serial", 32'(tx_serial),  32'd1);
      check("burst_gap1_active", 32'(tx_active),  32'd0);
      check("burst_gap1_level",  32'(fifo_level), 32'd1);
      tick();
      check_frame("bff", 8'hFF);
      tick();
      check("burst_gap2_serial", 32'(tx_serial),  32'd1);
      check("burst_gap2_level",  32'(fifo_level), 32'd0);
      tick();
      check_frame("b55", 8'h55);
      tick();
      check("burst_end_serial", 32'(tx_serial), 32'd1);
      check("burst_end_ovf",    32'(overflow),  32'd0);
      repeat (3) tick();

      // ---------------- fill and overflow ----------------
      write_byte(8'h11);                       // goes in flight
      tick();
      check("fill_inflight_level", 32'(fifo_level), 32'd0);
      write_byte(8'h21);
      check("fill_level1", 32'(fifo_level), 32'd1);
      write_byte(8'h22);
      write_byte(8'h23);
      check("fill_level3", 32'(fifo_level), 32'd3);
      check("fill_ready3", 32'(wr_ready),   32'd1);
      write_byte(8'h24);
      check("fill_level4", 32'(fifo_level), 32'd4);
      check("fill_ready4", 32'(wr_ready),   32'd0);
      check("fill_ovf_pre", 32'(overflow),  32'd0);
      write_byte(8'h99);                       // dropped
      check("ovf_set",       32'(overflow),   32'd1);
      check("ovf_level",     32'(fifo_level), 32'd4);
      wr_dv = 1'b1; wr_byte = 8'h99; clr_ovf = 1'b1;
      tick();                                  // set beats clear
      check("ovf_set_wins",  32'(overflow),   32'd1);
      wr_dv = 1'b0;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared",   32'(overflow),   32'd0);
      tick();
      check("ovf_stays_clr", 32'(overflow),   32'd0);

      seen = 1'b0;
      for (int k = 0; k < 80 && !seen; k++) begin
         tick();
         if (tx_done === 1'b1) seen = 1'b1;
      end
      check("fill_done_seen", 32'(seen), 32'd1);
      tick();                                  // pop from full
      check("refill_ready", 32'(wr_ready),   32'd1);
      check("refill_level", 32'(fifo_level), 32'd3);
      check("refill_gap",   32'(tx_serial),  32'd1);
      tick();
      check_frame("f21", 8'h21);
      tick(); tick();
      check_frame("f22", 8'h22);
      tick(); tick();
      check_frame("f23", 8'h23);
      tick(); tick();
      check_frame("f24", 8'h24);
      low_cnt = 0;
      repeat (60) begin
         tick();
         if (tx_serial !== 1'b1 || tx_active !== 1'b0) low_cnt++;
      end
      check("dropped_never_sent", 32'(low_cnt),    32'd0);
      check("drain_level",        32'(fifo_level), 32'd0);

      // ---------------- reset mid-frame ----------------
      write_byte(8'hC3);                       // edge N
      write_byte(8'h5A);                       // edge N+1: push + pop
      tick();                                  // frame cycle 1
      repeat (17) tick();                      // cycle 18: data bit 3
      check("mid_bit3_serial", 32'(tx_serial),  32'd0);
      check("mid_bit3_active", 32'(tx_active),  32'd1);
      check("mid_level_pre",   32'(fifo_level), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_serial", 32'(tx_serial),  32'd1);
      check("mid_rst_active", 32'(tx_active),  32'd0);
      check("mid_rst_level",  32'(fifo_level), 32'd0);
      check("mid_rst_ready",  32'(wr_ready),   32'd1);
      done_cnt = 0;
      repeat (3) begin
         tick();
         if (tx_done !== 1'b0) done_cnt++;
      end
      rst_n = 1'b1;
      low_cnt = 0;
      repeat (50) begin
         tick();
         if (tx_done !== 1'b0) done_cnt++;
         if (tx_serial !== 1'b1) low_cnt++;
      end
      check("mid_no_done",    32'(done_cnt),   32'd0);
      check("mid_line_high",  32'(low_cnt),    32'd0);
      check("mid_level_post", 32'(fifo_level), 32'd0);

`ifdef UART_TX_PARITY_EN
      // ---------------- parity ----------------
      write_byte(8'h07);
      tick(); tick();
      check_frame("p07", 8'h07);               // parity bit 1, 44 cycles
      tick();
      check("p07_end_active", 32'(tx_active), 32'd0);
      write_byte(8'h03);
      tick(); tick();
      check_frame("p03", 8'h03);               // parity bit 0
      tick();
      check("p03_end_active", 32'(tx_active), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
